// File: rtl/mips_bus_interface.sv
// mips_bus_interface: bridges CPU load/store requests onto an Avalon-MM master port,
// handling lane steering, sign/zero extension and alignment errors.
module mips_bus_interface (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        bad_req;
    logic        in_bus;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [3:0]  be_raw;
    logic [31:0] wd_raw;

    assign bad_req = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));

    // Little-endian lane selection from the latched address.
    assign ld_byte = readdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = readdata[{addr_q[1], 4'b0000} +: 16];
    assign ld_ext  = (size_q == 2'b00) ? {{24{signed_q & ld_byte[7]}}, ld_byte}
                   : (size_q == 2'b01) ? {{16{signed_q & ld_half[15]}}, ld_half}
                   : readdata;

    assign be_raw = (size_q == 2'b00) ? (4'b0001 << addr_q[1:0])
                  : (size_q == 2'b01) ? (addr_q[1] ? 4'b1100 : 4'b0011)
                  : 4'b1111;
    assign wd_raw = (size_q == 2'b00) ? {4{wdata_q[7:0]}}
                  : (size_q == 2'b01) ? {2{wdata_q[15:0]}}
                  : wdata_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        if (state_q == S_IDLE) begin
            if (req_valid) begin
                addr_d   = req_addr;
                size_d   = req_size;
                signed_d = req_signed;
                write_d  = req_write;
                wdata_d  = req_wdata;
                rdata_d  = 32'h0;
                error_d  = bad_req;
                state_d  = bad_req ? S_RESP : S_BUS;
            end
        end else if (state_q == S_BUS) begin
            if (!waitrequest) begin
                rdata_d = write_q ? 32'h0 : ld_ext;
                state_d = S_RESP;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Bus outputs are pure functions of latched state, so they stay stable under waitrequest.
    assign in_bus     = (state_q == S_BUS);
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_error = resp_valid & error_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign read       = in_bus & ~write_q;
    assign write      = in_bus & write_q;
    assign address    = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign byteenable = in_bus ? be_raw : 4'b0000;
    assign writedata  = in_bus ? wd_raw : 32'h0;
endmodule

// File: tb/tb_mips_bus_interface.sv
// tb_mips_bus_interface: directed vector table plus hand sequences for reset and back-to-back.
module tb_mips_bus_interface;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int checks = 0;
    int errors = 0;

    mips_bus_interface dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .address(address),
        .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Read and write must never be asserted together.
    always @(negedge clk) begin
        if (reset === 1'b0) chk("no_overlap", {31'h0, read & write}, 32'h0);
    end

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; waitrequest = 1'b0; readdata = 32'h0;
        chk("ready_idle", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err) begin
            chk("err_valid", {31'h0, resp_valid}, 32'h1);
            chk("err_flag", {31'h0, resp_error}, 32'h1);
            chk("err_rdata", resp_rdata, 32'h0);
            chk("err_nostrobe", {30'h0, read, write}, 32'h0);
        end else begin
            for (int i = 0; i <= v.waits; i++) begin
                waitrequest = (i < v.waits);
                readdata = (i < v.waits) ? ~v.rdata : v.rdata;
                chk("strobes", {30'h0, read, write}, v.wr ? 32'h1 : 32'h2);
                chk("address", address, v.exp_addr);
                chk("byteenable", {28'h0, byteenable}, {28'h0, v.exp_be});
                if (v.wr) chk("writedata", writedata, v.exp_wd);
                chk("no_resp_in_bus", {31'h0, resp_valid}, 32'h0);
                @(negedge clk);
            end
            waitrequest = 1'b0;
            readdata = 32'h0;
            chk("resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("resp_error", {31'h0, resp_error}, 32'h0);
            chk("resp_rdata", resp_rdata, v.exp_rdata);
            chk("resp_nostrobe", {30'h0, read, write}, 32'h0);
        end
        @(negedge clk);
        chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
        chk("back_ready", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'h100, 4'h8, 32'h0, 32'h00000080};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3, 1'b0, 32'h200, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h101, 32'h12345677, 32'hFFFFFFFF, 0, 1'b0, 32'h100, 4'h2, 32'h77777777, 32'h0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h12348001, 0, 1'b0, 32'h100, 4'h3, 32'h0, 32'hFFFF8001};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'hF00D1234, 2, 1'b0, 32'h300, 4'hC, 32'h0, 32'h0000F00D};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0, 1, 1'b0, 32'h404, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h201, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h00007F00, 0, 1'b0, 32'h100, 4'h2, 32'h0, 32'h0000007F};

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h5555AAAA; waitrequest = 1'b0; readdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_strobes", {30'h0, read, write}, 32'h0);
        chk("rst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_be", {28'h0, byteenable}, 32'h0);
        req_valid = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset while stalled in BUS aborts the access without a response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h500; waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_read_on", {31'h0, read}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_read_off", {31'h0, read}, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("abort_no_resp2", {31'h0, resp_valid}, 32'h0);
        waitrequest = 1'b0;
        run_vec(vecs[0]);

        // Back-to-back: req_valid held, second request waits for the cycle after resp_valid.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10;
        req_wdata = 32'h01020304; waitrequest = 1'b0; readdata = 32'h0;
        chk("b2b_acc1", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h20; req_signed = 1'b0; readdata = 32'hA5A5A5A5;
        chk("b2b_wr", {30'h0, read, write}, 32'h1);
        chk("b2b_busy", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("b2b_resp1", {31'h0, resp_valid}, 32'h1);
        chk("b2b_busy2", {31'h0, req_ready}, 32'h0);
        chk("b2b_idle_strobes", {30'h0, read, write}, 32'h0);
        @(negedge clk);
        chk("b2b_acc2", {31'h0, req_ready}, 32'h1);
        chk("b2b_pulse", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_rd", {30'h0, read, write}, 32'h2);
        chk("b2b_addr", address, 32'h20);
        @(negedge clk);
        chk("b2b_resp2", {31'h0, resp_valid}, 32'h1);
        chk("b2b_rdata", resp_rdata, 32'hA5A5A5A5);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
